// File: rtl/char_seq_pkg.sv
// Shared types and constants for the plate-character ROI sequencer.
package char_seq_pkg;

    localparam int CHAR_NUM = 7;
    localparam int POS_W    = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    typedef struct packed {
        logic [POS_W-1:0] x0;
        logic [POS_W-1:0] x1;
        logic [POS_W-1:0] y0;
        logic [POS_W-1:0] y1;
    } box_t;

    // part[k] holds partition_line(k+1)
    typedef struct packed {
        logic [POS_W-1:0]                  edge_left;
        logic [POS_W-1:0]                  edge_right;
        logic [POS_W-1:0]                  char_up;
        logic [POS_W-1:0]                  char_down;
        logic [CHAR_NUM-2:0][POS_W-1:0]    part;
    } snap_t;

endpackage

// File: rtl/char_cell_select.sv
// Combinational cell-box mux: picks the box for cell idx out of the frame snapshot
// and flags cells with zero or negative width/height.
module char_cell_select
    import char_seq_pkg::*;
(
    input  snap_t      snap,
    input  logic [2:0] idx,
    output box_t       box,
    output logic       degen
);

    // Column boundaries left to right: outer edges wrap the six partitions
    logic [CHAR_NUM:0][POS_W-1:0] lines;

    always_comb begin
        lines[0] = snap.edge_left;
        for (int i = 1; i < CHAR_NUM; i++) begin
            lines[i] = snap.part[i-1];
        end
        lines[CHAR_NUM] = snap.edge_right;
    end

    always_comb begin
        box.x0 = lines[idx];
        box.x1 = lines[idx + 3'd1];
        box.y0 = snap.char_up;
        box.y1 = snap.char_down;
        degen  = !((box.x1 > box.x0) && (box.y1 > box.y0));
    end

endmodule

// File: rtl/char_roi_sequencer.sv
// Walks the seven character cells of a valid plate and hands each to the recognition
// engine over req/ack/done. Optional ack-to-done timeout: define CHAR_SEQ_TIMEOUT_EN.
module char_roi_sequencer
    import char_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_end,
    input  logic                plate_valid,
    input  logic [POS_W-1:0]    edge_left,
    input  logic [POS_W-1:0]    edge_right,
    input  logic [POS_W-1:0]    partition_line1,
    input  logic [POS_W-1:0]    partition_line2,
    input  logic [POS_W-1:0]    partition_line3,
    input  logic [POS_W-1:0]    partition_line4,
    input  logic [POS_W-1:0]    partition_line5,
    input  logic [POS_W-1:0]    partition_line6,
    input  logic [POS_W-1:0]    char_up_position,
    input  logic [POS_W-1:0]    char_down_position,
    output logic                roi_req,
    input  logic                roi_ack,
    input  logic                roi_done,
    output logic [2:0]          roi_idx,
    output logic [POS_W-1:0]    roi_x0,
    output logic [POS_W-1:0]    roi_x1,
    output logic [POS_W-1:0]    roi_y0,
    output logic [POS_W-1:0]    roi_y1,
    output logic                seq_busy,
    output logic                seq_done,
    output logic [CHAR_NUM-1:0] skip_mask,
    output logic                timeout_err,
    output logic [7:0]          overrun_cnt
);

    state_e              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    snap_t               snap_q, snap_d;
    box_t                box_q, box_d;
    logic [CHAR_NUM-1:0] skip_q, skip_d;
    logic [7:0]          ovr_q, ovr_d;

    box_t                sel_box;
    logic                sel_degen;

`ifdef CHAR_SEQ_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                terr_q, terr_d;
`else
    logic                unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    char_cell_select u_sel (
        .snap  (snap_q),
        .idx   (idx_q),
        .box   (sel_box),
        .degen (sel_degen)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        box_d   = box_q;
        skip_d  = skip_q;
        ovr_d   = ovr_q;
`ifdef CHAR_SEQ_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        terr_d  = 1'b0;
`endif
        // A frame ending mid-sequence is dropped; the snapshot stays untouched
        if (frame_end && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_end && plate_valid) begin
                    snap_d.edge_left  = edge_left;
                    snap_d.edge_right = edge_right;
                    snap_d.char_up    = char_up_position;
                    snap_d.char_down  = char_down_position;
                    snap_d.part       = {partition_line6, partition_line5, partition_line4,
                                         partition_line3, partition_line2, partition_line1};
                    skip_d  = '0;
                    idx_d   = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (sel_degen) begin
                    skip_d[idx_q] = 1'b1;
                    state_d       = ST_NEXT;
                end else begin
                    box_d   = sel_box;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (roi_ack) begin
`ifdef CHAR_SEQ_TIMEOUT_EN
                    tcnt_d = '0;
`endif
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (roi_done) begin
                    state_d = ST_NEXT;
`ifdef CHAR_SEQ_TIMEOUT_EN
                end else if (tcnt_q == TCNT_W'(TIMEOUT_CYC)) begin
                    skip_d[idx_q] = 1'b1;
                    terr_d        = 1'b1;
                    state_d       = ST_NEXT;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
`endif
                end
            end
            ST_NEXT: begin
                if (idx_q == 3'(CHAR_NUM - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_CHECK;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            box_q   <= '0;
            skip_q  <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            box_q   <= box_d;
            skip_q  <= skip_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef CHAR_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            terr_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            terr_q <= terr_d;
        end
    end
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign roi_req     = (state_q == ST_ISSUE);
    assign seq_busy    = (state_q != ST_IDLE);
    assign seq_done    = (state_q == ST_DONE);
    assign roi_idx     = idx_q;
    assign roi_x0      = box_q.x0;
    assign roi_x1      = box_q.x1;
    assign roi_y0      = box_q.y0;
    assign roi_y1      = box_q.y1;
    assign skip_mask   = skip_q;
    assign overrun_cnt = ovr_q;

endmodule
